arf_err_stats: RTL and testbench

//  Consumes both ARF datapaths' outputs (variance-approximate, accurate) for ports 27/28, one sample per handshake.

---
 rtl/arf_pkg.sv | 31 +++
 rtl/arf_err_diff.sv | 42 ++++
 rtl/arf_err_stats.sv | 208 ++++++++++++++++++++
 tb/tb_arf_err_stats.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arf_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : arf_pkg                                                        |
// | Shared definitions for the ARF error-statistics block: default datapath  |
// | width and window size, the controller state encoding, and width helpers  |
// | used to size the accumulators.                                           |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package arf_pkg;

    localparam int ARF_DATA_W   = 32;
    localparam int ARF_WIN_LOG2 = 6;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        DRAIN  = 2'd1,
        REPORT = 2'd2
    } arf_state_t;

    // A signed sum of 2**win_log2 data_w-bit values needs win_log2 extra bits.
    function automatic int sum_width(input int data_w, input int win_log2);
        return data_w + win_log2;
    endfunction

    // A sum of 2**win_log2 squares (each 2*data_w bits) needs win_log2 extra bits.
    function automatic int sq_width(input int data_w, input int win_log2);
        return 2 * data_w + win_log2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arf_err_diff.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : arf_err_diff                                                   |
// | First pipeline stage for one channel: forms diff = var - acc (wrapping   |
// | modulo 2**DATA_W) and its magnitude, and registers both when load=1.     |
// | Ports   : clk, rst_n (sync, active-low), load (sample accepted),         |
// |           var_in / acc_in (operands), diff (two's complement result),    |
// |           mag (unsigned |diff|).                                         |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module arf_err_diff #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] var_in,
    input  logic [DATA_W-1:0] acc_in,
    output logic [DATA_W-1:0] diff,
    output logic [DATA_W-1:0] mag
);

    logic [DATA_W-1:0] diff_c;
    logic [DATA_W-1:0] mag_c;

    assign diff_c = var_in - acc_in;
    // Negating the most negative value gives back 2**(DATA_W-1), which is the
    // correct magnitude once read as unsigned.
    assign mag_c  = diff_c[DATA_W-1] ? (~diff_c + DATA_W'(1)) : diff_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            diff <= '0;
            mag  <= '0;
        end else if (load) begin
            diff <= diff_c;
            mag  <= mag_c;
        end
    end

endmodule
`default_nettype wire

// File: rtl/arf_err_stats.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : arf_err_stats                                                  |
// | Windowed error statistics between the approximate and accurate ARF       |
// | datapaths for ports 27 and 28. Per window of 2**WIN_LOG2 samples it      |
// | produces the signed sum, sum of squares and max magnitude of             |
// | diff = var - acc per channel, then hands a record downstream.            |
// | Ports   : clk, rst_n (sync, active-low), clear (sync flush),             |
// |           in_valid/in_ready + out27_var/acc, out28_var/acc (samples),    |
// |           stat_valid/stat_ready + stat_count/sum/sq/max (records).       |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module arf_err_stats
    import arf_pkg::*;
#(
    parameter int DATA_W   = ARF_DATA_W,
    parameter int WIN_LOG2 = ARF_WIN_LOG2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_W-1:0]              out27_var,
    input  logic [DATA_W-1:0]              out27_acc,
    input  logic [DATA_W-1:0]              out28_var,
    input  logic [DATA_W-1:0]              out28_acc,
    output logic                           stat_valid,
    input  logic                           stat_ready,
    output logic [WIN_LOG2:0]              stat_count,
    output logic [DATA_W+WIN_LOG2-1:0]     stat_sum27,
    output logic [DATA_W+WIN_LOG2-1:0]     stat_sum28,
    output logic [2*DATA_W+WIN_LOG2-1:0]   stat_sq27,
    output logic [2*DATA_W+WIN_LOG2-1:0]   stat_sq28,
    output logic [DATA_W-1:0]              stat_max27,
    output logic [DATA_W-1:0]              stat_max28
);

    localparam int SUM_W = sum_width(DATA_W, WIN_LOG2);
    localparam int SQ_W  = sq_width(DATA_W, WIN_LOG2);
    localparam int CNT_W = WIN_LOG2 + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = {1'b0, {WIN_LOG2{1'b1}}};

    arf_state_t state;
    arf_state_t state_nxt;

    logic [CNT_W-1:0]    count;
    logic                s1_valid;
    logic                accept;

    logic [DATA_W-1:0]   diff27;
    logic [DATA_W-1:0]   mag27;
    logic [DATA_W-1:0]   diff28;
    logic [DATA_W-1:0]   mag28;

    logic [2*DATA_W-1:0] mag27_x;
    logic [2*DATA_W-1:0] mag28_x;
    logic [2*DATA_W-1:0] sq27;
    logic [2*DATA_W-1:0] sq28;

    logic [SUM_W-1:0]    sum27_acc;
    logic [SUM_W-1:0]    sum28_acc;
    logic [SQ_W-1:0]     sq27_acc;
    logic [SQ_W-1:0]     sq28_acc;
    logic [DATA_W-1:0]   max27_acc;
    logic [DATA_W-1:0]   max28_acc;

    // clear drops any sample presented in the same cycle.
    assign accept = in_valid & in_ready & ~clear;

    // ---------------------------------------------------------------- S1
    arf_err_diff #(.DATA_W(DATA_W)) u_diff27 (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept),
        .var_in (out27_var),
        .acc_in (out27_acc),
        .diff   (diff27),
        .mag    (mag27)
    );

    arf_err_diff #(.DATA_W(DATA_W)) u_diff28 (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept),
        .var_in (out28_var),
        .acc_in (out28_acc),
        .diff   (diff28),
        .mag    (mag28)
    );

    // ---------------------------------------------------------------- S2 squarers
    assign mag27_x = {{DATA_W{1'b0}}, mag27};
    assign mag28_x = {{DATA_W{1'b0}}, mag28};
    assign sq27    = mag27_x * mag27_x;
    assign sq28    = mag28_x * mag28_x;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        stat_valid = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = (count <= LAST_CNT);
                if (in_valid && in_ready && (count == LAST_CNT)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Once S1 is empty the last sample has reached the accumulators.
                if (!s1_valid) begin
                    state_nxt = REPORT;
                end
            end
            REPORT: begin
                stat_valid = 1'b1;
                if (stat_ready) begin
                    state_nxt = ACCUM;
                end
            end
            default: state_nxt = ACCUM;
        endcase
        if (clear) begin
            state_nxt = ACCUM;
        end
    end

    // ---------------------------------------------------------------- counters, accumulators, records
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count      <= '0;
            s1_valid   <= 1'b0;
            sum27_acc  <= '0;
            sum28_acc  <= '0;
            sq27_acc   <= '0;
            sq28_acc   <= '0;
            max27_acc  <= '0;
            max28_acc  <= '0;
            stat_count <= '0;
            stat_sum27 <= '0;
            stat_sum28 <= '0;
            stat_sq27  <= '0;
            stat_sq28  <= '0;
            stat_max27 <= '0;
            stat_max28 <= '0;
        end else if (clear) begin
            // Record outputs deliberately keep their last values.
            count      <= '0;
            s1_valid   <= 1'b0;
            sum27_acc  <= '0;
            sum28_acc  <= '0;
            sq27_acc   <= '0;
            sq28_acc   <= '0;
            max27_acc  <= '0;
            max28_acc  <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                count <= count + CNT_W'(1);
            end

            if (s1_valid) begin
                sum27_acc <= sum27_acc + {{WIN_LOG2{diff27[DATA_W-1]}}, diff27};
                sum28_acc <= sum28_acc + {{WIN_LOG2{diff28[DATA_W-1]}}, diff28};
                sq27_acc  <= sq27_acc + {{WIN_LOG2{1'b0}}, sq27};
                sq28_acc  <= sq28_acc + {{WIN_LOG2{1'b0}}, sq28};
                if (mag27 > max27_acc) begin
                    max27_acc <= mag27;
                end
                if (mag28 > max28_acc) begin
                    max28_acc <= mag28;
                end
            end

            if ((state == DRAIN) && !s1_valid) begin
                stat_count <= count;
                stat_sum27 <= sum27_acc;
                stat_sum28 <= sum28_acc;
                stat_sq27  <= sq27_acc;
                stat_sq28  <= sq28_acc;
                stat_max27 <= max27_acc;
                stat_max28 <= max28_acc;
            end

            // s1_valid is always 0 in REPORT, so this never races an update.
            if ((state == REPORT) && stat_ready) begin
                count     <= '0;
                sum27_acc <= '0;
                sum28_acc <= '0;
                sq27_acc  <= '0;
                sq28_acc  <= '0;
                max27_acc <= '0;
                max28_acc <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_arf_err_stats.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module  : tb_arf_err_stats                                               |
// | Self-checking bench for arf_err_stats: table of whole-window vectors     |
// | with hand-computed statistics, plus reset, backpressure, clear and       |
// | random-operand windows checked against a small reference model.         |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_arf_err_stats;

    localparam int DW = 32;
    localparam int WL = 6;
    localparam int SW = DW + WL;
    localparam int QW = 2 * DW + WL;
    localparam int NS = 1 << WL;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out27_var = '0;
    logic [DW-1:0] out27_acc = '0;
    logic [DW-1:0] out28_var = '0;
    logic [DW-1:0] out28_acc = '0;
    logic          stat_valid;
    logic          stat_ready = 1'b1;
    logic [WL:0]   stat_count;
    logic [SW-1:0] stat_sum27;
    logic [SW-1:0] stat_sum28;
    logic [QW-1:0] stat_sq27;
    logic [QW-1:0] stat_sq28;
    logic [DW-1:0] stat_max27;
    logic [DW-1:0] stat_max28;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    arf_err_stats #(.DATA_W(DW), .WIN_LOG2(WL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out27_var  (out27_var),
        .out27_acc  (out27_acc),
        .out28_var  (out28_var),
        .out28_acc  (out28_acc),
        .stat_valid (stat_valid),
        .stat_ready (stat_ready),
        .stat_count (stat_count),
        .stat_sum27 (stat_sum27),
        .stat_sum28 (stat_sum28),
        .stat_sq27  (stat_sq27),
        .stat_sq28  (stat_sq28),
        .stat_max27 (stat_max27),
        .stat_max28 (stat_max28)
    );

    // One window: sample 0 uses the explicit operands, samples 1..63 use a
    // random acc with var = acc + off (so diff = off modulo 2**32).
    typedef struct {
        logic [DW-1:0] v27_0, a27_0, v28_0, a28_0, off27, off28;
        logic [SW-1:0] sum27, sum28;
        logic [QW-1:0] sq27, sq28;
        logic [DW-1:0] max27, max28;
    } vec_t;

    vec_t vecs[4];

    function automatic logic [SW-1:0] s38(input longint x);
        return x[SW-1:0];
    endfunction

    function automatic vec_t mk(
        input logic [DW-1:0] v27_0, a27_0, v28_0, a28_0, off27, off28,
        input logic [SW-1:0] sum27, sum28,
        input logic [QW-1:0] sq27, sq28,
        input logic [DW-1:0] max27, max28);
        vec_t v;
        v.v27_0 = v27_0; v.a27_0 = a27_0; v.v28_0 = v28_0; v.a28_0 = a28_0;
        v.off27 = off27; v.off28 = off28;
        v.sum27 = sum27; v.sum28 = sum28; v.sq27 = sq27; v.sq28 = sq28;
        v.max27 = max27; v.max28 = max28;
        return v;
    endfunction

    task automatic chk(input string name, input logic [QW-1:0] act, input logic [QW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Called at a negedge; returns at the negedge right after acceptance.
    task automatic send(input logic [DW-1:0] v27, a27, v28, a28);
        int t = 0;
        in_valid  = 1'b1;
        out27_var = v27; out27_acc = a27;
        out28_var = v28; out28_acc = a28;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) timeout("send");
        @(negedge clk);
    endtask

    task automatic idle_gap(input bit gaps);
        if (gaps && ($urandom_range(0, 2) == 0)) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
    endtask

    task automatic run_window(input vec_t v, input bit gaps);
        logic [DW-1:0] a27, a28;
        for (int i = 0; i < NS; i++) begin
            idle_gap(gaps);
            if (i == 0) begin
                send(v.v27_0, v.a27_0, v.v28_0, v.a28_0);
            end else begin
                a27 = $urandom;
                a28 = $urandom;
                send(a27 + v.off27, a27, a28 + v.off28, a28);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_stat(input string name);
        int t = 0;
        while (!stat_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!stat_valid) timeout(name);
    endtask

    task automatic check_stats(input vec_t v, input string tag);
        chk({tag, ".count"}, QW'(stat_count), QW'(NS));
        chk({tag, ".sum27"}, QW'(stat_sum27), QW'(v.sum27));
        chk({tag, ".sum28"}, QW'(stat_sum28), QW'(v.sum28));
        chk({tag, ".sq27"},  stat_sq27, v.sq27);
        chk({tag, ".sq28"},  stat_sq28, v.sq28);
        chk({tag, ".max27"}, QW'(stat_max27), QW'(v.max27));
        chk({tag, ".max28"}, QW'(stat_max28), QW'(v.max28));
    endtask

    task automatic run_random(input int w);
        vec_t e;
        longint s27 = 0, s28 = 0, d27, d28, m27, m28;
        logic [QW-1:0] q27 = '0, q28 = '0;
        logic [DW-1:0] x27 = '0, x28 = '0;
        logic [DW-1:0] v27, a27, v28, a28;
        for (int i = 0; i < NS; i++) begin
            v27 = DW'($urandom_range(0, 4095)); a27 = DW'($urandom_range(0, 4095));
            v28 = DW'($urandom_range(0, 4095)); a28 = DW'($urandom_range(0, 4095));
            d27 = longint'(v27) - longint'(a27);
            d28 = longint'(v28) - longint'(a28);
            m27 = (d27 < 0) ? -d27 : d27;
            m28 = (d28 < 0) ? -d28 : d28;
            s27 += d27;
            s28 += d28;
            q27 += QW'(m27) * QW'(m27);
            q28 += QW'(m28) * QW'(m28);
            if (DW'(m27) > x27) x27 = DW'(m27);
            if (DW'(m28) > x28) x28 = DW'(m28);
            idle_gap(1'b1);
            send(v27, a27, v28, a28);
        end
        in_valid = 1'b0;
        e = mk('0, '0, '0, '0, '0, '0, s38(s27), s38(s28), q27, q28, x27, x28);
        wait_stat($sformatf("rnd%0d", w));
        check_stats(e, $sformatf("rnd%0d", w));
    endtask

    initial begin
        vecs[0] = mk(32'd103, 32'd100, 32'd95, 32'd100, 32'd3, 32'hFFFF_FFFB,
                     s38(192), s38(-320), QW'(576), QW'(1600), 32'd3, 32'd5);
        vecs[1] = mk(32'h0000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 32'd0,
                     s38(-(64'sd1 <<< 31)), s38(-1), QW'(1) << 62, QW'(1),
                     32'h8000_0000, 32'd1);
        vecs[2] = mk(32'h7FFF_FFFF, 32'h8000_0000, 32'd1000, 32'd0, 32'hFFFF_FFFF, 32'd1000,
                     s38(-64), s38(64000), QW'(64), QW'(64000000), 32'd1, 32'd1000);
        vecs[3] = mk(32'h7FFF_FFFF, 32'd0, 32'h8000_0000, 32'd0, 32'h7FFF_FFFF, 32'h8000_0000,
                     s38(64 * 64'sd2147483647), s38(-(64'sd1 <<< 37)),
                     QW'(64) * (QW'(32'h7FFF_FFFF) * QW'(32'h7FFF_FFFF)), QW'(1) << 68,
                     32'h7FFF_FFFF, 32'h8000_0000);

        // Reset with junk on the inputs.
        in_valid = 1'b1;
        out27_var = 32'h1234_5678; out28_var = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.stat_valid", QW'(stat_valid), QW'(0));
        chk("rst.in_ready",   QW'(in_ready),   QW'(1));
        chk("rst.count",      QW'(stat_count), QW'(0));
        chk("rst.sum27",      QW'(stat_sum27), QW'(0));
        chk("rst.sum28",      QW'(stat_sum28), QW'(0));
        chk("rst.sq27",       stat_sq27,       QW'(0));
        chk("rst.sq28",       stat_sq28,       QW'(0));
        chk("rst.max27",      QW'(stat_max27), QW'(0));
        chk("rst.max28",      QW'(stat_max28), QW'(0));

        // Table of whole windows; odd entries get random bubbles.
        for (int k = 0; k < 4; k++) begin
            run_window(vecs[k], k[0]);
            wait_stat($sformatf("vec%0d", k));
            check_stats(vecs[k], $sformatf("vec%0d", k));
        end

        // Backpressure: record must hold and no sample may be taken.
        @(negedge clk);
        stat_ready = 1'b0;
        run_window(vecs[0], 1'b0);
        wait_stat("bp");
        check_stats(vecs[0], "bp");
        in_valid = 1'b1;
        out27_var = 32'd999; out27_acc = 32'd0; out28_var = 32'd0; out28_acc = 32'd999;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp.stat_valid", QW'(stat_valid), QW'(1));
            chk("bp.in_ready",   QW'(in_ready),   QW'(0));
            chk("bp.sum27",      QW'(stat_sum27), QW'(vecs[0].sum27));
            chk("bp.sq28",       stat_sq28,       vecs[0].sq28);
        end
        in_valid = 1'b0;
        stat_ready = 1'b1;
        @(negedge clk);
        chk("bp.rel_valid", QW'(stat_valid), QW'(0));
        chk("bp.rel_ready", QW'(in_ready),   QW'(1));
        chk("bp.rel_keep",  QW'(stat_max28), QW'(vecs[0].max28));
        run_window(vecs[2], 1'b1);
        wait_stat("bp_next");
        check_stats(vecs[2], "bp_next");

        // Clear at sample 30: partial window and the same-cycle sample vanish.
        @(negedge clk);
        for (int i = 0; i < 30; i++) begin
            send(32'd100, 32'd0, 32'd7, 32'd0);
        end
        clear = 1'b1;
        out27_var = 32'd5000; out27_acc = 32'd0;
        @(negedge clk);
        clear = 1'b0;
        in_valid = 1'b0;
        chk("clr.stat_valid", QW'(stat_valid), QW'(0));
        chk("clr.in_ready",   QW'(in_ready),   QW'(1));
        chk("clr.keep_sum28", QW'(stat_sum28), QW'(vecs[2].sum28));
        run_window(vecs[0], 1'b1);
        wait_stat("clr_next");
        check_stats(vecs[0], "clr_next");

        // Random operands with bubbles against the reference model.
        for (int w = 0; w < 20; w++) begin
            run_random(w);
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        n_err++;
        $display("FAIL watchdog: simulation did not complete");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1);
    end

endmodule
`default_nettype wire
